shared_mem_arbiter: RTL and testbench

SHARED_MEM_ARBITER -- requirements
Module: shared_mem_arbiter

---
 rtl/shared_mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_shared_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter that lets NUM_CORES requesters share one memory port.
// The FSM runs IDLE -> ISSUE -> RESP. A transaction that gets no sm_ack in time
// is completed with zero load data and sets a sticky timeout flag.
module shared_mem_arbiter #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_CORES-1:0]          mem_req_ld,
    input  logic [NUM_CORES-1:0]          mem_req_st,
    input  logic [NUM_CORES*ADDR_W-1:0]   addr_in,
    input  logic [NUM_CORES*DATA_W-1:0]   wdata_in,
    output logic [NUM_CORES-1:0]          val_data,
    output logic [DATA_W-1:0]             mem_dat,
    output logic                          sm_req,
    output logic                          sm_we,
    output logic [ADDR_W-1:0]             sm_addr,
    output logic [DATA_W-1:0]             sm_wdata,
    input  logic                          sm_ack,
    input  logic [DATA_W-1:0]             sm_rdata,
    output logic                          busy,
    output logic [3:0]                    gnt_id,
    output logic                          err_timeout,
    output logic                          err_proto,
    input  logic                          err_clr
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e                  r_state;
    logic [3:0]              r_rr_ptr;
    logic [3:0]              r_gnt_id;
    logic [NUM_CORES-1:0]    r_val_data;
    logic [DATA_W-1:0]       r_mem_dat;
    logic                    r_sm_req;
    logic                    r_sm_we;
    logic [ADDR_W-1:0]       r_sm_addr;
    logic [DATA_W-1:0]       r_sm_wdata;
    logic [7:0]              r_cnt;
    logic                    r_err_timeout;
    logic                    r_err_proto;

    logic [NUM_CORES-1:0]    w_req;
    logic [2*NUM_CORES-1:0]  w_rot;
    logic                    w_found;
    logic [4:0]              w_sum;
    logic [3:0]              w_win;
    logic [ADDR_W-1:0]       w_addr;
    logic [DATA_W-1:0]       w_wdata;
    logic                    w_ld;
    logic                    w_st;
    logic [NUM_CORES-1:0]    w_onehot;
    logic                    w_any_req;
    logic [3:0]              w_next_ptr;

    // Round-robin winner search plus mux of the winner's request fields
    always_comb begin
        w_req     = mem_req_ld | mem_req_st;
        w_any_req = |w_req;
        // Rotating a doubled copy puts rr_ptr at bit 0, so the first set bit wins
        w_rot     = {w_req, w_req} >> r_rr_ptr;
        w_found   = 1'b0;
        w_sum     = '0;
        w_win     = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_rr_ptr} + 5'(i);
                if (w_sum >= 5'(NUM_CORES)) begin
                    w_sum = w_sum - 5'(NUM_CORES);
                end
                w_win = w_sum[3:0];
            end
        end
        w_addr   = '0;
        w_wdata  = '0;
        w_ld     = 1'b0;
        w_st     = 1'b0;
        w_onehot = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (w_win == 4'(k)) begin
                w_addr  = addr_in[k*ADDR_W +: ADDR_W];
                w_wdata = wdata_in[k*DATA_W +: DATA_W];
                w_ld    = mem_req_ld[k];
                w_st    = mem_req_st[k];
            end
            w_onehot[k] = (r_gnt_id == 4'(k));
        end
        w_next_ptr = (r_gnt_id == 4'(NUM_CORES - 1)) ? 4'd0 : r_gnt_id + 4'd1;
    end

    // Transaction FSM with all outputs registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= StIdle;
            r_rr_ptr      <= '0;
            r_gnt_id      <= '0;
            r_val_data    <= '0;
            r_mem_dat     <= '0;
            r_sm_req      <= 1'b0;
            r_sm_we       <= 1'b0;
            r_sm_addr     <= '0;
            r_sm_wdata    <= '0;
            r_cnt         <= '0;
            r_err_timeout <= 1'b0;
            r_err_proto   <= 1'b0;
        end else begin
            // Clear first; a flag set later in this block overrides the clear
            if (err_clr) begin
                r_err_timeout <= 1'b0;
                r_err_proto   <= 1'b0;
            end
            case (r_state)
                StIdle: begin
                    r_val_data <= '0;
                    if (w_any_req) begin
                        r_gnt_id   <= w_win;
                        r_sm_addr  <= w_addr;
                        r_sm_wdata <= w_wdata;
                        // Load wins when both ld and st are asserted
                        r_sm_we    <= w_st & ~w_ld;
                        r_sm_req   <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= StIssue;
                        if (w_ld && w_st) begin
                            r_err_proto <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    if (sm_ack) begin
                        if (!r_sm_we) begin
                            r_mem_dat <= sm_rdata;
                        end
                        r_sm_req   <= 1'b0;
                        r_val_data <= w_onehot;
                        r_state    <= StResp;
                    end else if (r_cnt == 8'(TIMEOUT - 1)) begin
                        r_sm_req      <= 1'b0;
                        r_err_timeout <= 1'b1;
                        r_mem_dat     <= '0;
                        r_val_data    <= w_onehot;
                        r_state       <= StResp;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                StResp: begin
                    r_val_data <= '0;
                    r_rr_ptr   <= w_next_ptr;
                    r_state    <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign val_data    = r_val_data;
    assign mem_dat     = r_mem_dat;
    assign sm_req      = r_sm_req;
    assign sm_we       = r_sm_we;
    assign sm_addr     = r_sm_addr;
    assign sm_wdata    = r_sm_wdata;
    assign busy        = (r_state != StIdle);
    assign gnt_id      = r_gnt_id;
    assign err_timeout = r_err_timeout;
    assign err_proto   = r_err_proto;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter: 4 cores, 12-bit address, 8-bit data, TIMEOUT=8.
module tb_shared_mem_arbiter;

    localparam int NC = 4;
    localparam int AW = 12;
    localparam int DW = 8;

    logic            clk;
    logic            reset_n;
    logic [NC-1:0]   mem_req_ld;
    logic [NC-1:0]   mem_req_st;
    logic [NC*AW-1:0] addr_in;
    logic [NC*DW-1:0] wdata_in;
    logic [NC-1:0]   val_data;
    logic [DW-1:0]   mem_dat;
    logic            sm_req;
    logic            sm_we;
    logic [AW-1:0]   sm_addr;
    logic [DW-1:0]   sm_wdata;
    logic            sm_ack;
    logic [DW-1:0]   sm_rdata;
    logic            busy;
    logic [3:0]      gnt_id;
    logic            err_timeout;
    logic            err_proto;
    logic            err_clr;

    int checks;
    int errors;

    shared_mem_arbiter #(
        .NUM_CORES (NC),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .TIMEOUT   (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mem_req_ld  (mem_req_ld),
        .mem_req_st  (mem_req_st),
        .addr_in     (addr_in),
        .wdata_in    (wdata_in),
        .val_data    (val_data),
        .mem_dat     (mem_dat),
        .sm_req      (sm_req),
        .sm_we       (sm_we),
        .sm_addr     (sm_addr),
        .sm_wdata    (sm_wdata),
        .sm_ack      (sm_ack),
        .sm_rdata    (sm_rdata),
        .busy        (busy),
        .gnt_id      (gnt_id),
        .err_timeout (err_timeout),
        .err_proto   (err_proto),
        .err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        mem_req_ld = '0; mem_req_st = '0; addr_in = '0; wdata_in = '0;
        sm_ack = 1'b0; sm_rdata = '0; err_clr = 1'b0;
        reset_n = 1'b0;
        #3;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (sm_req !== 1'b0) begin errors++; $display("FAIL reset_sm_req got %b want 0", sm_req); end
        checks++; if (val_data !== 4'b0000) begin errors++; $display("FAIL reset_val got %b want 0000", val_data); end
        checks++; if ({sm_we, sm_addr, sm_wdata, mem_dat} !== 29'd0) begin errors++;
            $display("FAIL reset_data got we=%b a=%h w=%h d=%h want zeros", sm_we, sm_addr, sm_wdata, mem_dat); end
        checks++; if ({gnt_id, err_timeout, err_proto} !== 6'd0) begin errors++;
            $display("FAIL reset_flags got gnt=%0d to=%b pr=%b want 0", gnt_id, err_timeout, err_proto); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_load();
        addr_in[2*AW +: AW] = 12'h0A5;
        mem_req_ld = 4'b0100;
        tick();
        checks++; if ({sm_req, sm_we, sm_addr} !== {1'b1, 1'b0, 12'h0A5}) begin errors++;
            $display("FAIL load_issue got req=%b we=%b a=%h want 1 0 0a5", sm_req, sm_we, sm_addr); end
        checks++; if ({busy, gnt_id, val_data} !== {1'b1, 4'd2, 4'b0000}) begin errors++;
            $display("FAIL load_issue_state got busy=%b gnt=%0d val=%b want 1 2 0000", busy, gnt_id, val_data); end
        sm_ack = 1'b1; sm_rdata = 8'h3C;
        tick();
        sm_ack = 1'b0; sm_rdata = 8'h00;
        checks++; if (val_data !== 4'b0100 || mem_dat !== 8'h3C) begin errors++;
            $display("FAIL load_resp got val=%b dat=%h want 0100 3c", val_data, mem_dat); end
        checks++; if (sm_req !== 1'b0) begin errors++; $display("FAIL load_req_drop got %b want 0", sm_req); end
        mem_req_ld = '0;
        tick();
        checks++; if (val_data !== 4'b0000 || mem_dat !== 8'h3C || busy !== 1'b0) begin errors++;
            $display("FAIL load_after got val=%b dat=%h busy=%b want 0000 3c 0", val_data, mem_dat, busy); end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_order [6];
        int n;
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        apply_reset();
        n = 0;
        mem_req_ld = 4'b1111;
        // Ack held high the whole time: ISSUE lasts one cycle, ack elsewhere is ignored
        sm_ack = 1'b1; sm_rdata = 8'h5A;
        for (int c = 0; c < 40 && n < 6; c++) begin
            tick();
            if (val_data !== 4'b0000) begin
                checks++; if (val_data !== exp_order[n]) begin errors++;
                    $display("FAIL fair_grant%0d got %b want %b", n, val_data, exp_order[n]); end
                n++;
                if (n == 6) mem_req_ld = '0;
            end
        end
        checks++; if (n != 6) begin errors++; $display("FAIL fair_count got %0d want 6", n); end
        sm_ack = 1'b0; sm_rdata = 8'h00;
        tick();
        checks++; if (busy !== 1'b0 || mem_dat !== 8'h5A) begin errors++;
            $display("FAIL fair_idle got busy=%b dat=%h want 0 5a", busy, mem_dat); end
    endtask

    task automatic test_store();
        addr_in[1*AW +: AW] = 12'hFFF;
        wdata_in[1*DW +: DW] = 8'h81;
        mem_req_st = 4'b0010;
        tick();
        // Changes after the grant must not reach the memory port
        addr_in[1*AW +: AW] = 12'h123;
        wdata_in[1*DW +: DW] = 8'h44;
        for (int c = 0; c < 5; c++) begin
            checks++; if ({sm_req, sm_we, sm_addr, sm_wdata, val_data} !== {1'b1, 1'b1, 12'hFFF, 8'h81, 4'b0000}) begin
                errors++;
                $display("FAIL store_hold%0d got req=%b we=%b a=%h w=%h val=%b want 1 1 fff 81 0000",
                         c, sm_req, sm_we, sm_addr, sm_wdata, val_data);
            end
            tick();
        end
        sm_ack = 1'b1; sm_rdata = 8'hEE;
        tick();
        sm_ack = 1'b0; mem_req_st = '0;
        checks++; if (val_data !== 4'b0010 || mem_dat !== 8'h5A) begin errors++;
            $display("FAIL store_resp got val=%b dat=%h want 0010 5a", val_data, mem_dat); end
        tick();
    endtask

    task automatic test_timeout();
        int bad;
        bad = 0;
        addr_in[0 +: AW] = 12'h321;
        mem_req_ld = 4'b0001;
        tick();
        for (int c = 0; c < 8; c++) begin
            if (sm_req !== 1'b1 || val_data !== 4'b0000) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL to_issue_cycles got %0d bad want 0", bad); end
        checks++; if ({sm_req, err_timeout, val_data, mem_dat} !== {1'b0, 1'b1, 4'b0001, 8'h00}) begin errors++;
            $display("FAIL to_resp got req=%b to=%b val=%b dat=%h want 0 1 0001 00", sm_req, err_timeout, val_data, mem_dat); end
        mem_req_ld = '0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_clear got %b want 0", err_timeout); end
    endtask

    task automatic test_proto();
        mem_req_ld = 4'b0001; mem_req_st = 4'b0001;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if ({sm_we, gnt_id, err_proto} !== {1'b0, 4'd0, 1'b1}) begin errors++;
            $display("FAIL proto_issue got we=%b gnt=%0d pr=%b want 0 0 1", sm_we, gnt_id, err_proto); end
        sm_ack = 1'b1; sm_rdata = 8'h77;
        tick();
        sm_ack = 1'b0; mem_req_ld = '0; mem_req_st = '0;
        checks++; if (val_data !== 4'b0001 || mem_dat !== 8'h77) begin errors++;
            $display("FAIL proto_resp got val=%b dat=%h want 0001 77", val_data, mem_dat); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (err_proto !== 1'b0) begin errors++; $display("FAIL proto_clear got %b want 0", err_proto); end
    endtask

    task automatic test_reset_mid_issue();
        int pulses;
        pulses = 0;
        addr_in[2*AW +: AW] = 12'h777;
        mem_req_ld = 4'b0100;
        tick();
        checks++; if (sm_req !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got %b want 1", sm_req); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (sm_req !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL rst_mid_async got req=%b busy=%b want 0 0", sm_req, busy); end
        sm_ack = 1'b1; sm_rdata = 8'h99;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (val_data !== 4'b0000) pulses++;
        end
        checks++; if (pulses != 0 || mem_dat !== 8'h00) begin errors++;
            $display("FAIL rst_mid_noval got pulses=%0d dat=%h want 0 00", pulses, mem_dat); end
        sm_ack = 1'b0;
        reset_n = 1'b1;
        addr_in[0 +: AW] = 12'h010;
        addr_in[3*AW +: AW] = 12'h030;
        mem_req_ld = 4'b1001;
        tick();
        checks++; if (gnt_id !== 4'd0 || sm_addr !== 12'h010) begin errors++;
            $display("FAIL rst_first_gnt got gnt=%0d a=%h want 0 010", gnt_id, sm_addr); end
        sm_ack = 1'b1; sm_rdata = 8'h11;
        tick();
        sm_ack = 1'b0;
        checks++; if (val_data !== 4'b0001) begin errors++; $display("FAIL rst_first_val got %b want 0001", val_data); end
        mem_req_ld = 4'b1000;
        tick();
        checks++; if (val_data !== 4'b0000) begin errors++; $display("FAIL rst_idle_val got %b want 0000", val_data); end
        tick();
        checks++; if (gnt_id !== 4'd3 || sm_addr !== 12'h030) begin errors++;
            $display("FAIL rst_second_gnt got gnt=%0d a=%h want 3 030", gnt_id, sm_addr); end
        mem_req_ld = '0;
        sm_ack = 1'b1;
        tick();
        sm_ack = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_load();
        test_fairness();
        test_store();
        test_timeout();
        test_proto();
        test_reset_mid_issue();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
